// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the HI/LO path; result packed as {remainder, quotient}.
// Latency: start sampled in cycle 0 -> ready_o in cycle WIDTH+1 (cycle 2 for divide-by-zero, cycle 1 on early exit).
// No backpressure: start_i is ignored while busy_o=1, annul_i cancels work in DIVZERO/ON. Optional macro: DIV_EARLY_EXIT_EN.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   op0_i,
  input  logic [WIDTH-1:0]   op1_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;    // partial remainder
  logic [WIDTH-1:0] quo;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;    // divisor magnitude
  logic             neg_q;
  logic             neg_r;

  // Operand magnitudes; unsigned mode passes operands through untouched.
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  logic [WIDTH-1:0] mag0, mag1;
  logic             div_zero;
  logic             early;

  assign mag0     = (signed_i && op0_i[WIDTH-1]) ? -op0_i : op0_i;
  assign mag1     = (signed_i && op1_i[WIDTH-1]) ? -op1_i : op1_i;
  assign div_zero = (op1_i == '0);

`ifdef DIV_EARLY_EXIT_EN
  // Dividend smaller than divisor: quotient is zero and remainder is the dividend itself.
  assign early = (mag0 < mag1);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift {rem, quo} left, trial-subtract divisor, quotient bit = NOT borrow.
  // When there is no borrow the difference is below the divisor, so its low WIDTH bits are exact.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] rem_fix, quo_fix;
  logic             last_step;

  assign trial     = {rem, quo[WIDTH-1]};
  assign borrow    = (trial < {1'b0, dvs});
  assign diff      = trial[WIDTH-1:0] - dvs;
  assign rem_step  = borrow ? trial[WIDTH-1:0] : diff;
  assign quo_step  = {quo[WIDTH-2:0], ~borrow};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign quo_fix   = neg_q ? -quo_step : quo_step;
  assign rem_fix   = neg_r ? -rem_step : rem_step;

  // Next-state selection; annul wins over completion in DIVZERO and ON.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (div_zero)   state_nxt = S_DIVZERO;
          else if (early) state_nxt = S_END;
          else            state_nxt = S_ON;
        end
      end
      S_DIVZERO: state_nxt = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)        state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      dbz_o    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_o <= (state_nxt == S_END);
      busy_o  <= (state_nxt != S_IDLE);
      dbz_o   <= (state == S_DIVZERO) && (state_nxt == S_END);
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            rem   <= '0;
            // On divide-by-zero the raw dividend is parked here to become HI.
            quo   <= div_zero ? op0_i : mag0;
            dvs   <= mag1;
            neg_q <= signed_i & (op0_i[WIDTH-1] ^ op1_i[WIDTH-1]);
            neg_r <= signed_i & op0_i[WIDTH-1];
            cnt   <= '0;
            if (!div_zero && early)
              result_o <= {op0_i, {WIDTH{1'b0}}};
          end
        end
        S_DIVZERO: begin
          if (!annul_i)
            result_o <= {quo, {WIDTH{1'b1}}};
        end
        S_ON: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CNT_W'(1);
          if (!annul_i && last_step)
            result_o <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule
